tail_wr_arbiter: RTL and testbench



---
 rtl/tail_wr_arbiter.sv | 123 ++++++++++++
 tb/tb_tail_wr_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/tail_wr_arbiter.sv
// Write-port controller for the tail table: runs an initialisation walk after reset or
// flush, then round-robin arbitrates two valid/ready requesters onto the single write port.
module tail_wr_arbiter #(
  parameter int            DEPTH     = 40,
  parameter int            AW        = 6,
  parameter int            DW        = 6,
  parameter logic [DW-1:0] INIT_DATA = '0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          W0_en,
  output logic [AW-1:0] W0_addr,
  output logic [DW-1:0] W0_data,
  output logic          init_busy,
  output logic          err_oob,
  output logic          err_sticky
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          rr_q, rr_d;
  logic          w_en_q, w_en_d;
  logic [AW-1:0] w_addr_q, w_addr_d;
  logic [DW-1:0] w_data_q, w_data_d;
  logic          err_oob_q, err_oob_d;
  logic          err_sticky_q, err_sticky_d;

  logic          grant0, grant1;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  function automatic logic in_range(input logic [AW-1:0] a);
    return (32'(a) < DEPTH);
  endfunction

  // rr_q names the requester that wins when both are valid.
  always_comb begin
    grant0     = req0_valid & (~req1_valid | ~rr_q);
    grant1     = req1_valid & (~req0_valid | rr_q);
    req0_ready = (state_q == ST_RUN) & ~flush & grant0;
    req1_ready = (state_q == ST_RUN) & ~flush & grant1;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_d         = rr_q;
    w_en_d       = 1'b0;
    w_addr_d     = w_addr_q;
    w_data_d     = w_data_q;
    err_oob_d    = 1'b0;
    err_sticky_d = err_sticky_q;
    sel_addr     = req1_ready ? req1_addr : req0_addr;
    sel_data     = req1_ready ? req1_data : req0_data;

    if (flush) begin
      state_d = ST_INIT;
      cnt_d   = '0;
    end else if (state_q == ST_INIT) begin
      w_en_d   = 1'b1;
      w_addr_d = cnt_q;
      w_data_d = INIT_DATA;
      if (cnt_q == AW'(DEPTH - 1)) begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (req0_ready | req1_ready) begin
      rr_d = req0_ready;
      // Out-of-range requests complete the handshake but never reach the table.
      if (in_range(sel_addr)) begin
        w_en_d   = 1'b1;
        w_addr_d = sel_addr;
        w_data_d = sel_data;
      end else begin
        err_oob_d    = 1'b1;
        err_sticky_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      rr_q         <= 1'b0;
      w_en_q       <= 1'b0;
      w_addr_q     <= '0;
      w_data_q     <= '0;
      err_oob_q    <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_q         <= rr_d;
      w_en_q       <= w_en_d;
      w_addr_q     <= w_addr_d;
      w_data_q     <= w_data_d;
      err_oob_q    <= err_oob_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign W0_en      = w_en_q;
  assign W0_addr    = w_addr_q;
  assign W0_data    = w_data_q;
  assign err_oob    = err_oob_q;
  assign err_sticky = err_sticky_q;
  assign init_busy  = (state_q == ST_INIT);

endmodule

// File: tb/tb_tail_wr_arbiter.sv
// Bench for tail_wr_arbiter: vector table plus init-walk, flush and reset sequences,
// with expected write-port results queued at drive time and compared one cycle later.
module tb_tail_wr_arbiter;
  localparam int DEPTH = 40;
  localparam int AW    = 6;
  localparam int DW    = 6;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          req0_ready, req1_ready;
  logic          W0_en;
  logic [AW-1:0] W0_addr;
  logic [DW-1:0] W0_data;
  logic          init_busy, err_oob, err_sticky;

  tail_wr_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .INIT_DATA(6'h00)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .W0_en(W0_en), .W0_addr(W0_addr), .W0_data(W0_data),
    .init_busy(init_busy), .err_oob(err_oob), .err_sticky(err_sticky)
  );

  always #5 clock = ~clock;

  // Table written from the write port, read asynchronously.
  logic [DW-1:0] mem [0:DEPTH-1];
  always @(posedge clock) if (W0_en && W0_addr < 6'(DEPTH)) mem[W0_addr] <= W0_data;

  typedef struct packed {
    logic v0; logic [5:0] a0; logic [5:0] d0;
    logic v1; logic [5:0] a1; logic [5:0] d1;
    logic fl;
    logic r0; logic r1; logic busy;
    logic en; logic [5:0] addr; logic [5:0] data; logic oob; logic sticky;
    logic rdc; logic [5:0] rda; logic [5:0] rdd;
  } vec_t;

  int   n_checks = 0;
  int   n_err    = 0;
  vec_t sbq[$];
  vec_t tbl[14];
  vec_t v;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Called at a falling edge: drive, check readies, queue expectation, check next outputs.
  task automatic run_vec(input vec_t s);
    vec_t e;
    req0_valid = s.v0; req0_addr = s.a0; req0_data = s.d0;
    req1_valid = s.v1; req1_addr = s.a1; req1_data = s.d1;
    flush      = s.fl;
    #1;
    chk("req0_ready", req0_ready, s.r0);
    chk("req1_ready", req1_ready, s.r1);
    chk("init_busy", init_busy, s.busy);
    sbq.push_back(s);
    @(posedge clock);
    @(negedge clock);
    e = sbq.pop_front();
    chk("W0_en", W0_en, e.en);
    if (e.en) begin
      chk("W0_addr", W0_addr, e.addr);
      chk("W0_data", W0_data, e.data);
    end
    chk("err_oob", err_oob, e.oob);
    chk("err_sticky", err_sticky, e.sticky);
    if (e.rdc) chk("table_read", mem[e.rda], e.rdd);
  endtask

  function automatic vec_t walk(input int k, input logic stk, input logic v0);
    vec_t w;
    w = '0;
    w.v0 = v0; w.a0 = 6'd7; w.d0 = 6'h11;
    w.busy = 1'b1; w.en = 1'b1; w.addr = 6'(k); w.data = 6'h00; w.sticky = stk;
    return w;
  endfunction

  function automatic vec_t mk(input logic v0, input logic [5:0] a0, input logic [5:0] d0,
                              input logic v1, input logic [5:0] a1, input logic [5:0] d1,
                              input logic fl, input logic r0, input logic r1, input logic busy,
                              input logic en, input logic [5:0] addr, input logic [5:0] data,
                              input logic oob, input logic stk);
    vec_t w;
    w = '0;
    w.v0 = v0; w.a0 = a0; w.d0 = d0; w.v1 = v1; w.a1 = a1; w.d1 = d1; w.fl = fl;
    w.r0 = r0; w.r1 = r1; w.busy = busy;
    w.en = en; w.addr = addr; w.data = data; w.oob = oob; w.sticky = stk;
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //                v0  a0     d0     v1  a1     d1     fl r0 r1 bsy en addr   data   oob stk
    tbl[0]  = mk(1, 6'd7,  6'h11, 0, 6'd0,  6'h00, 0, 1, 0, 0, 1, 6'd7,  6'h11, 0, 0);
    tbl[1]  = mk(1, 6'd5,  6'h2A, 0, 6'd0,  6'h00, 0, 1, 0, 0, 1, 6'd5,  6'h2A, 0, 0);
    tbl[2]  = mk(0, 6'd0,  6'h00, 0, 6'd0,  6'h00, 0, 0, 0, 0, 0, 6'd0,  6'h00, 0, 0);
    tbl[2].rdc = 1'b1; tbl[2].rda = 6'd5; tbl[2].rdd = 6'h2A;
    tbl[3]  = mk(0, 6'd0,  6'h00, 1, 6'd39, 6'h15, 0, 0, 1, 0, 1, 6'd39, 6'h15, 0, 0);
    tbl[4]  = mk(1, 6'd1,  6'h01, 1, 6'd2,  6'h02, 0, 1, 0, 0, 1, 6'd1,  6'h01, 0, 0);
    tbl[5]  = mk(1, 6'd1,  6'h01, 1, 6'd2,  6'h02, 0, 0, 1, 0, 1, 6'd2,  6'h02, 0, 0);
    tbl[6]  = mk(1, 6'd1,  6'h01, 1, 6'd2,  6'h02, 0, 1, 0, 0, 1, 6'd1,  6'h01, 0, 0);
    tbl[7]  = mk(1, 6'd1,  6'h01, 1, 6'd2,  6'h02, 0, 0, 1, 0, 1, 6'd2,  6'h02, 0, 0);
    tbl[8]  = mk(1, 6'd1,  6'h01, 0, 6'd0,  6'h00, 0, 1, 0, 0, 1, 6'd1,  6'h01, 0, 0);
    tbl[9]  = mk(0, 6'd0,  6'h00, 1, 6'd40, 6'h3F, 0, 0, 1, 0, 0, 6'd0,  6'h00, 1, 1);
    tbl[10] = mk(0, 6'd0,  6'h00, 0, 6'd0,  6'h00, 0, 0, 0, 0, 0, 6'd0,  6'h00, 0, 1);
    tbl[10].rdc = 1'b1; tbl[10].rda = 6'd39; tbl[10].rdd = 6'h15;
    tbl[11] = mk(1, 6'd63, 6'h01, 0, 6'd0,  6'h00, 0, 1, 0, 0, 0, 6'd0,  6'h00, 1, 1);
    tbl[12] = mk(1, 6'd0,  6'h0A, 0, 6'd0,  6'h00, 0, 1, 0, 0, 1, 6'd0,  6'h0A, 0, 1);
    tbl[13] = mk(1, 6'd4,  6'h04, 0, 6'd0,  6'h00, 1, 0, 0, 0, 0, 6'd0,  6'h00, 0, 1);

    // Held in reset with a request pending: nothing may be granted or written.
    req0_valid = 1'b1;
    @(negedge clock); @(negedge clock);
    chk("rst_W0_en", W0_en, 0);
    chk("rst_W0_addr", W0_addr, 0);
    chk("rst_W0_data", W0_data, 0);
    chk("rst_err_oob", err_oob, 0);
    chk("rst_err_sticky", err_sticky, 0);
    chk("rst_init_busy", init_busy, 1);
    chk("rst_req0_ready", req0_ready, 0);
    reset = 1'b0;

    // Init walk with req0 waiting; it is served in the first RUN cycle.
    for (int k = 0; k < DEPTH; k++) run_vec(walk(k, 1'b0, 1'b1));
    for (int i = 0; i < 14; i++) run_vec(tbl[i]);

    // Walk after flush, interrupted by a second flush at its 21st cycle.
    for (int k = 0; k < 20; k++) run_vec(walk(k, 1'b1, 1'b0));
    run_vec(mk(1, 6'd4, 6'h04, 0, 6'd0, 6'h00, 1, 0, 0, 1, 0, 6'd0, 6'h00, 0, 1));
    for (int k = 0; k < DEPTH; k++) run_vec(walk(k, 1'b1, 1'b0));
    v = '0; v.rdc = 1'b1; v.rda = 6'd5; v.rdd = 6'h00; v.sticky = 1'b1;
    run_vec(v);

    // Round-robin pointer survives flush: req1 wins first.
    run_vec(mk(1, 6'd10, 6'h1A, 1, 6'd11, 6'h1B, 0, 0, 1, 0, 1, 6'd11, 6'h1B, 0, 1));
    run_vec(mk(1, 6'd10, 6'h1A, 0, 6'd0,  6'h00, 0, 1, 0, 0, 1, 6'd10, 6'h1A, 0, 1));
    run_vec(mk(1, 6'd12, 6'h2C, 0, 6'd0,  6'h00, 0, 1, 0, 0, 1, 6'd12, 6'h2C, 0, 1));

    // Asynchronous reset while the write port is active.
    req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0;
    reset = 1'b1;
    #1;
    chk("arst_W0_en", W0_en, 0);
    chk("arst_W0_addr", W0_addr, 0);
    chk("arst_err_sticky", err_sticky, 0);
    chk("arst_init_busy", init_busy, 1);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < DEPTH; k++) run_vec(walk(k, 1'b0, 1'b0));
    run_vec(mk(0, 6'd0,  6'h00, 0, 6'd0,  6'h00, 0, 0, 0, 0, 0, 6'd0,  6'h00, 0, 0));
    run_vec(mk(1, 6'd20, 6'h05, 1, 6'd21, 6'h06, 0, 1, 0, 0, 1, 6'd20, 6'h05, 0, 0));
    run_vec(mk(0, 6'd0,  6'h00, 1, 6'd21, 6'h06, 0, 0, 1, 0, 1, 6'd21, 6'h06, 0, 0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
